stonyman_frame_sequencer: RTL and testbench
===========================================

Name: stonyman_frame_sequencer

Overview:
- Frame-level controller that scans the Stonyman image sensor pixel array and acquires each pixel through the serial ADC capture block.
- Drives sensor pointer strobes (resv/incv/resp/incp/inphi) and starts one ADC conversion per pixel.
- Emits each pixel with row/col tags on a valid/ready stream toward frame buffer or MSS fabric interface.
- Sits between the MSS fabric (start/status) and the sensor + ADC capture datapath; replaces the tied-off startCapture.

Parameters:
- ROWS, 112, sensor rows scanned per frame (>=1)
- COLS, 112, sensor columns scanned per row (>=1)
- PIX_W, 10, ADC sample width
- PULSE_CYC, 2, strobe high time and following low gap in clk cycles (>=1)
- SETTLE_CYC, 8, cycles after inphi gap before ADC start (>=1)
- ADC_TIMEOUT, 1024, max cycles waiting for adc_done

Ports:
- clk  in  1  fabric clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to capture a frame
- busy  out  1  high from accepted start until frame end
- frame_done  out  1  one-cycle pulse at frame end
- error  out  1  sticky ADC-timeout flag, cleared by next accepted start
- resv, incv, resp, incp, inphi  out  1 each  sensor strobes
- adc_start  out  1  one-cycle conversion request
- adc_done  in  1  one-cycle conversion-complete pulse
- adc_data  in  PIX_W  sample, valid when adc_done=1
- pix_valid  out  1  pixel available
- pix_ready  in  1  consumer accepts pixel
- pix_data  out  PIX_W  pixel value
- pix_row  out  7  row index of pixel (clog2(ROWS))
- pix_col  out  7  column index of pixel (clog2(COLS))

Behaviour:
- Reset: every output is 0; state IDLE; row/col counters 0. Reset mid-frame aborts immediately: strobes drop the same edge and no frame_done is issued.
- Strobe timing: a "pulse X" is X=1 for PULSE_CYC cycles, then X=0 for PULSE_CYC cycles. At most one strobe is high at any time.
- IDLE: start=1 -> RESV, busy=1, error cleared. start while busy is ignored.
- RESV: pulse resv, row=0 -> ROW.
- ROW: pulse resp, col=0 -> PHI.
- PHI: pulse inphi -> SETTLE.
- SETTLE: wait SETTLE_CYC cycles -> CONV with adc_start=1 for exactly one cycle on entry.
- CONV: on adc_done, latch adc_data into pix_data, set pix_valid=1 with the current row/col on the next cycle -> OUT.
  - If ADC_TIMEOUT cycles elapse with no adc_done: error=1, frame aborted -> DONE.
  - adc_done outside CONV is ignored.
- OUT: hold pix_valid and pix_data/row/col stable until pix_valid & pix_ready. On that cycle pix_valid drops, then:
  - col<COLS-1: pulse incp, col++ -> PHI.
  - col==COLS-1 and row<ROWS-1: pulse incv, row++ -> ROW.
  - otherwise -> DONE.
- No incp follows the last column of a row; no incv follows the last row.
- DONE: frame_done=1 for one cycle, busy=0 the same cycle -> IDLE. A start in that cycle is ignored.
- Counters must not wrap: ROWS=1 and COLS=1 are legal (single pixel, zero incp/incv).
- Per frame: resv=1 pulse, resp=ROWS pulses, incv=ROWS-1, incp=ROWS*(COLS-1), inphi=ROWS*COLS, adc_start=ROWS*COLS, pix beats=ROWS*COLS in raster order.

Decomposition:
- Shared package stonyman_pkg:
  - state enum (IDLE, RESV, ROW, PHI, SETTLE, CONV, OUT, DONE)
  - sensor geometry constants (112x112)
  - index width function
- Sub-module strobe_pulser: given go and a strobe select, generates the PULSE_CYC-high/PULSE_CYC-low shape and a finished pulse. Instantiated once and shared by all five strobes.

Test Plan:
- ROWS=2, COLS=3, PULSE_CYC=2, SETTLE_CYC=4; start pulse; ADC model returns adc_done 5 cycles after adc_start with data 0x100+pixel index; pix_ready=1 -> resv 1, resp 2, incv 1, incp 4, inphi 6, adc_start 6; pix beats (r,c,data) = (0,0,0x100)..(1,2,0x105); one frame_done; busy low after.
- Same config, pix_ready low for 10 cycles on beat (0,1) -> pix_valid/data/row/col stable for 10 cycles; no incp and no adc_start during the stall; remaining beats unchanged.
- ADC model never answers the 3rd conversion, ADC_TIMEOUT=16 -> error=1 after 16 cycles in CONV; frame_done pulses; 2 beats emitted; the next start clears error.
- Assert reset during SETTLE of pixel (1,1) -> all outputs 0 next cycle; a new start produces a full correct 6-beat frame starting at resv.
- start pulsed while busy, and in the frame_done cycle -> ignored, exactly one frame produced.
- ROWS=1, COLS=1 -> resv 1, resp 1, inphi 1, adc_start 1, zero incp/incv, one beat (0,0), frame_done.

Source files
------------

// File: rtl/stonyman_pkg.sv
// rtl/stonyman_pkg.sv - shared states, strobe selects, geometry and index-width helper for the Stonyman frame sequencer
package stonyman_pkg;

    localparam int SENSOR_ROWS = 112;
    localparam int SENSOR_COLS = 112;

    typedef enum logic [2:0] {
        IDLE,
        RESV,
        ROW,
        PHI,
        SETTLE,
        CONV,
        OUT,
        DONE
    } seq_state_e;

    typedef enum logic [2:0] {
        STB_RESV,
        STB_INCV,
        STB_RESP,
        STB_INCP,
        STB_INPHI
    } strobe_sel_e;

    // Counter width for indices 0..n-1, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stonyman_frame_sequencer_strobe_pulser.sv
// rtl/stonyman_frame_sequencer_strobe_pulser.sv - shared high/low pulse shaper for the five sensor strobes
module strobe_pulser
    import stonyman_pkg::*;
#(
    parameter int PULSE_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  strobe_sel_e sel,
    output logic        resv,
    output logic        incv,
    output logic        resp,
    output logic        incp,
    output logic        inphi,
    output logic        finished
);

    localparam int CNT_W = $clog2(PULSE_CYC + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PULSE_CYC - 1);

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_HIGH,
        PH_LOW
    } phase_e;

    phase_e           phase_q;
    phase_e           phase_d;
    strobe_sel_e      sel_q;
    logic [CNT_W-1:0] cnt_q;
    logic             high;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= PH_IDLE;
            sel_q   <= STB_RESV;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            if (go) begin
                sel_q <= sel;
            end
            if (go || cnt_q == LAST) begin
                cnt_q <= '0;
            end else if (phase_q != PH_IDLE) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // finished marks the last low cycle so the caller can chain the next pulse without a gap.
    always_comb begin
        phase_d  = phase_q;
        finished = 1'b0;
        case (phase_q)
            PH_HIGH: begin
                if (cnt_q == LAST) begin
                    phase_d = PH_LOW;
                end
            end
            PH_LOW: begin
                if (cnt_q == LAST) begin
                    phase_d  = PH_IDLE;
                    finished = 1'b1;
                end
            end
            default: ;
        endcase
        if (go) begin
            phase_d = PH_HIGH;
        end
    end

    assign high  = (phase_q == PH_HIGH);
    assign resv  = high && (sel_q == STB_RESV);
    assign incv  = high && (sel_q == STB_INCV);
    assign resp  = high && (sel_q == STB_RESP);
    assign incp  = high && (sel_q == STB_INCP);
    assign inphi = high && (sel_q == STB_INPHI);

endmodule

// File: rtl/stonyman_frame_sequencer.sv
// rtl/stonyman_frame_sequencer.sv - scans the Stonyman pixel array, runs one ADC conversion per pixel and streams tagged pixels
module stonyman_frame_sequencer
    import stonyman_pkg::*;
#(
    parameter int ROWS        = SENSOR_ROWS,
    parameter int COLS        = SENSOR_COLS,
    parameter int PIX_W       = 10,
    parameter int PULSE_CYC   = 2,
    parameter int SETTLE_CYC  = 8,
    parameter int ADC_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   error,
    output logic                   resv,
    output logic                   incv,
    output logic                   resp,
    output logic                   incp,
    output logic                   inphi,
    output logic                   adc_start,
    input  logic                   adc_done,
    input  logic [PIX_W-1:0]       adc_data,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic [PIX_W-1:0]       pix_data,
    output logic [idx_w(ROWS)-1:0] pix_row,
    output logic [idx_w(COLS)-1:0] pix_col
);

    localparam int ROW_W    = idx_w(ROWS);
    localparam int COL_W    = idx_w(COLS);
    localparam int WAIT_MAX = (ADC_TIMEOUT > SETTLE_CYC) ? ADC_TIMEOUT : SETTLE_CYC;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

    localparam logic [ROW_W-1:0]  ROW_LAST    = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]  COL_LAST    = COL_W'(COLS - 1);
    localparam logic [WAIT_W-1:0] SETTLE_LAST = WAIT_W'(SETTLE_CYC - 1);
    localparam logic [WAIT_W-1:0] CONV_LAST   = WAIT_W'(ADC_TIMEOUT - 1);

    seq_state_e        state_q;
    seq_state_e        state_d;
    logic [ROW_W-1:0]  row_q;
    logic [COL_W-1:0]  col_q;
    logic [WAIT_W-1:0] wait_q;
    logic              acked_q;
    logic              go;
    strobe_sel_e       go_sel;
    logic              pulse_fin;
    logic              handshake;
    logic              last_col;
    logic              last_row;

    assign last_col  = (col_q == COL_LAST);
    assign last_row  = (row_q == ROW_LAST);
    assign handshake = pix_valid && pix_ready;

    strobe_pulser #(
        .PULSE_CYC (PULSE_CYC)
    ) u_pulser (
        .clk      (clk),
        .reset    (reset),
        .go       (go),
        .sel      (go_sel),
        .resv     (resv),
        .incv     (incv),
        .resp     (resp),
        .incp     (incp),
        .inphi    (inphi),
        .finished (pulse_fin)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Each strobe state launches the next pulse in the same cycle the current one finishes.
    always_comb begin
        state_d = state_q;
        go      = 1'b0;
        go_sel  = STB_RESV;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RESV;
                    go      = 1'b1;
                    go_sel  = STB_RESV;
                end
            end
            RESV: begin
                if (pulse_fin) begin
                    state_d = ROW;
                    go      = 1'b1;
                    go_sel  = STB_RESP;
                end
            end
            ROW: begin
                if (pulse_fin) begin
                    state_d = PHI;
                    go      = 1'b1;
                    go_sel  = STB_INPHI;
                end
            end
            PHI: begin
                if (pulse_fin) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (wait_q == SETTLE_LAST) begin
                    state_d = CONV;
                end
            end
            CONV: begin
                if (adc_done) begin
                    state_d = OUT;
                end else if (wait_q == CONV_LAST) begin
                    state_d = DONE;
                end
            end
            OUT: begin
                if (!acked_q) begin
                    if (handshake) begin
                        if (!last_col) begin
                            go     = 1'b1;
                            go_sel = STB_INCP;
                        end else if (!last_row) begin
                            go     = 1'b1;
                            go_sel = STB_INCV;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end else if (pulse_fin) begin
                    go = 1'b1;
                    if (!last_col) begin
                        state_d = PHI;
                        go_sel  = STB_INPHI;
                    end else begin
                        state_d = ROW;
                        go_sel  = STB_RESP;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // acked_q: pixel handed off, the incp/incv advance pulse is still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_q     <= '0;
            col_q     <= '0;
            wait_q    <= '0;
            acked_q   <= 1'b0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            error     <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                wait_q <= '0;
            end else if (state_q == SETTLE || state_q == CONV) begin
                wait_q <= wait_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        error <= 1'b0;
                        row_q <= '0;
                        col_q <= '0;
                    end
                end
                CONV: begin
                    if (adc_done) begin
                        pix_data  <= adc_data;
                        pix_valid <= 1'b1;
                    end else if (wait_q == CONV_LAST) begin
                        error <= 1'b1;
                    end
                end
                OUT: begin
                    if (handshake) begin
                        pix_valid <= 1'b0;
                        acked_q   <= !(last_col && last_row);
                    end
                    if (acked_q && pulse_fin) begin
                        acked_q <= 1'b0;
                        if (!last_col) begin
                            col_q <= col_q + 1'b1;
                        end else begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    row_q <= '0;
                    col_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state_q != IDLE) && (state_q != DONE);
    assign frame_done = (state_q == DONE);
    assign adc_start  = (state_q == CONV) && (wait_q == '0);
    assign pix_row    = row_q;
    assign pix_col    = col_q;

endmodule

// File: tb/tb_stonyman_frame_sequencer.sv
// tb/tb_stonyman_frame_sequencer.sv - directed scoreboard bench for stonyman_frame_sequencer (2x3 and 1x1 geometries)
`timescale 1ns/1ps
module tb_stonyman_frame_sequencer;

    localparam int R   = 2;
    localparam int C   = 3;
    localparam int PW  = 10;
    localparam int PC  = 2;
    localparam int SC  = 4;
    localparam int TO  = 16;
    localparam int LAT = 5;

    typedef struct {
        logic [0:0]    row;
        logic [1:0]    col;
        logic [PW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start_a, busy_a, fd_a, err_a, resv_a, incv_a, resp_a, incp_a, inphi_a, adc_start_a;
    logic adc_done_a = 1'b0;
    logic pix_valid_a, pix_ready_a;
    logic [PW-1:0] adc_data_a = '0;
    logic [PW-1:0] pix_data_a;
    logic [0:0] pix_row_a;
    logic [1:0] pix_col_a;

    logic start_b, busy_b, fd_b, err_b, resv_b, incv_b, resp_b, incp_b, inphi_b, adc_start_b;
    logic adc_done_b = 1'b0;
    logic pix_valid_b, pix_ready_b;
    logic [PW-1:0] adc_data_b = '0;
    logic [PW-1:0] pix_data_b;
    logic [0:0] pix_row_b;
    logic [0:0] pix_col_b;

    stonyman_frame_sequencer #(
        .ROWS(R), .COLS(C), .PIX_W(PW), .PULSE_CYC(PC), .SETTLE_CYC(SC), .ADC_TIMEOUT(TO)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .frame_done(fd_a), .error(err_a),
        .resv(resv_a), .incv(incv_a), .resp(resp_a), .incp(incp_a), .inphi(inphi_a),
        .adc_start(adc_start_a), .adc_done(adc_done_a), .adc_data(adc_data_a),
        .pix_valid(pix_valid_a), .pix_ready(pix_ready_a), .pix_data(pix_data_a),
        .pix_row(pix_row_a), .pix_col(pix_col_a)
    );

    stonyman_frame_sequencer #(
        .ROWS(1), .COLS(1), .PIX_W(PW), .PULSE_CYC(PC), .SETTLE_CYC(SC), .ADC_TIMEOUT(TO)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .frame_done(fd_b), .error(err_b),
        .resv(resv_b), .incv(incv_b), .resp(resp_b), .incp(incp_b), .inphi(inphi_b),
        .adc_start(adc_start_b), .adc_done(adc_done_b), .adc_data(adc_data_b),
        .pix_valid(pix_valid_b), .pix_ready(pix_ready_b), .pix_data(pix_data_b),
        .pix_row(pix_row_b), .pix_col(pix_col_b)
    );

    int checks = 0;
    int errors = 0;
    beat_t exp_q[$];
    beat_t exp_qb[$];
    beat_t e_a, e_b;
    int cnt_a[6];
    int cnt_b[6];
    int beats_a = 0, beats_b = 0, fd_cnt_a = 0, fd_cnt_b = 0;
    logic [5:0] prev_a = '0, prev_b = '0;
    wire [5:0] stb_a = {adc_start_a, inphi_a, incp_a, resp_a, incv_a, resv_a};
    wire [5:0] stb_b = {adc_start_b, inphi_b, incp_b, resp_b, incv_b, resv_b};

    // ADC models: answer LAT cycles after adc_start with 0x100 + conversion index within the frame.
    int cd_a = 0, conv_a = 0, drop_idx = -1, cd_b = 0, conv_b = 0;
    logic [PW-1:0] pend_a = '0, pend_b = '0;

    always @(negedge clk) begin
        adc_done_a = 1'b0;
        if (reset) begin
            cd_a = 0;
        end else begin
            if (resv_a) conv_a = 0;
            if (cd_a > 0) begin
                cd_a--;
                if (cd_a == 0) begin
                    adc_done_a = 1'b1;
                    adc_data_a = pend_a;
                end
            end
            if (adc_start_a) begin
                if (conv_a != drop_idx) cd_a = LAT;
                pend_a = PW'(32'h100 + conv_a);
                conv_a++;
            end
        end
    end

    always @(negedge clk) begin
        adc_done_b = 1'b0;
        if (reset) begin
            cd_b = 0;
        end else begin
            if (resv_b) conv_b = 0;
            if (cd_b > 0) begin
                cd_b--;
                if (cd_b == 0) begin
                    adc_done_b = 1'b1;
                    adc_data_b = pend_b;
                end
            end
            if (adc_start_b) begin
                cd_b = LAT;
                pend_b = PW'(32'h100 + conv_b);
                conv_b++;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 6; i++) if (stb_a[i] && !prev_a[i]) cnt_a[i]++;
        prev_a = stb_a;
        if (fd_a) fd_cnt_a++;
        checks++;
        assert ($countones(stb_a[4:0]) <= 1) else begin
            errors++;
            $error("FAIL strobe_onehot_a observed=%b expected=at most one high", stb_a[4:0]);
        end
        if (pix_valid_a && pix_ready_a) begin
            beats_a++;
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL beat_unexpected_a observed=(%0d,%0d,0x%0h) expected=no beat", pix_row_a, pix_col_a, pix_data_a);
            end
            if (exp_q.size() > 0) begin
                e_a = exp_q.pop_front();
                checks++;
                assert (pix_row_a === e_a.row && pix_col_a === e_a.col && pix_data_a === e_a.data) else begin
                    errors++;
                    $error("FAIL beat_a observed=(%0d,%0d,0x%0h) expected=(%0d,%0d,0x%0h)",
                           pix_row_a, pix_col_a, pix_data_a, e_a.row, e_a.col, e_a.data);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 6; i++) if (stb_b[i] && !prev_b[i]) cnt_b[i]++;
        prev_b = stb_b;
        if (fd_b) fd_cnt_b++;
        if (pix_valid_b && pix_ready_b) begin
            beats_b++;
            checks++;
            assert (exp_qb.size() > 0) else begin
                errors++;
                $error("FAIL beat_unexpected_b observed=(%0d,%0d,0x%0h) expected=no beat", pix_row_b, pix_col_b, pix_data_b);
            end
            if (exp_qb.size() > 0) begin
                e_b = exp_qb.pop_front();
                checks++;
                assert (pix_row_b === e_b.row && 2'(pix_col_b) === e_b.col && pix_data_b === e_b.data) else begin
                    errors++;
                    $error("FAIL beat_b observed=(%0d,%0d,0x%0h) expected=(%0d,%0d,0x%0h)",
                           pix_row_b, pix_col_b, pix_data_b, e_b.row, e_b.col, e_b.data);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.row  = 1'(i / C);
            b.col  = 2'(i % C);
            b.data = PW'(32'h100 + i);
            exp_q.push_back(b);
        end
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        int n = 0;
        while (!fd_a && n < 2000) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(fd_a), 1);
    endtask

    task automatic check_counts(input string tag, input int cur[6], input int base[6],
                                input int e_resv, input int e_incv, input int e_resp,
                                input int e_incp, input int e_inphi, input int e_adc);
        chk({tag, "_resv"},  cur[0] - base[0], e_resv);
        chk({tag, "_incv"},  cur[1] - base[1], e_incv);
        chk({tag, "_resp"},  cur[2] - base[2], e_resp);
        chk({tag, "_incp"},  cur[3] - base[3], e_incp);
        chk({tag, "_inphi"}, cur[4] - base[4], e_inphi);
        chk({tag, "_adc"},   cur[5] - base[5], e_adc);
    endtask

    initial begin
        int base[6];
        int base2[6];
        int b0, f0, n, seen;
        beat_t bb;

        reset = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        pix_ready_a = 1'b1;
        pix_ready_b = 1'b1;
        tick(3);
        chk("reset_outputs_a", 32'({busy_a, fd_a, err_a, resv_a, incv_a, resp_a, incp_a, inphi_a, adc_start_a,
                                    pix_valid_a, pix_data_a, pix_row_a, pix_col_a}), 0);
        chk("reset_outputs_b", 32'({busy_b, fd_b, err_b, resv_b, incv_b, resp_b, incp_b, inphi_b, adc_start_b,
                                    pix_valid_b, pix_data_b, pix_row_b, pix_col_b}), 0);
        reset = 1'b0;
        tick(2);

        // Nominal frame; extra starts while busy and in the frame_done cycle must be ignored.
        base = cnt_a; b0 = beats_a; f0 = fd_cnt_a;
        push_frame(R * C);
        pulse_start_a();
        chk("frame1_busy_after_start", 32'(busy_a), 1);
        tick(5);
        pulse_start_a();
        wait_done_a("frame1_done");
        chk("frame1_busy_in_done", 32'(busy_a), 0);
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        tick(40);
        chk("frame1_idle_busy", 32'(busy_a), 0);
        check_counts("frame1", cnt_a, base, 1, R - 1, R, R * (C - 1), R * C, R * C);
        chk("frame1_beats", beats_a - b0, R * C);
        chk("frame1_frame_done", fd_cnt_a - f0, 1);
        chk("frame1_queue_empty", exp_q.size(), 0);
        chk("frame1_error", 32'(err_a), 0);

        // Back-pressure on beat (0,1).
        base = cnt_a; b0 = beats_a; f0 = fd_cnt_a;
        push_frame(R * C);
        pulse_start_a();
        n = 0;
        while (beats_a - b0 < 1 && n < 500) begin tick(1); n++; end
        chk("stall_first_beat", beats_a - b0, 1);
        pix_ready_a = 1'b0;
        n = 0;
        while (!pix_valid_a && n < 500) begin tick(1); n++; end
        chk("stall_valid", 32'(pix_valid_a), 1);
        base2 = cnt_a;
        for (int i = 0; i < 10; i++) begin
            chk("stall_hold", 32'({pix_valid_a, pix_row_a, pix_col_a, pix_data_a}), 32'({1'b1, 1'b0, 2'd1, 10'h101}));
            tick(1);
        end
        chk("stall_no_incp", cnt_a[3] - base2[3], 0);
        chk("stall_no_adc_start", cnt_a[5] - base2[5], 0);
        pix_ready_a = 1'b1;
        wait_done_a("stall_done");
        tick(3);
        check_counts("stall", cnt_a, base, 1, R - 1, R, R * (C - 1), R * C, R * C);
        chk("stall_beats", beats_a - b0, R * C);
        chk("stall_queue_empty", exp_q.size(), 0);

        // Third conversion never answered: timeout aborts the frame.
        drop_idx = 2;
        base = cnt_a; b0 = beats_a; f0 = fd_cnt_a;
        push_frame(2);
        pulse_start_a();
        seen = 0; n = 0;
        while (n < 1000) begin
            if (adc_start_a) seen++;
            if (seen == 3) break;
            tick(1);
            n++;
        end
        chk("timeout_third_conv", seen, 3);
        n = 0;
        while (!err_a && n < 100) begin tick(1); n++; end
        chk("timeout_cycles", n, TO);
        chk("timeout_frame_done", 32'(fd_a), 1);
        chk("timeout_busy", 32'(busy_a), 0);
        drop_idx = -1;
        tick(3);
        chk("timeout_beats", beats_a - b0, 2);
        chk("timeout_queue_empty", exp_q.size(), 0);
        chk("timeout_error_sticky", 32'(err_a), 1);
        chk("timeout_frame_done_count", fd_cnt_a - f0, 1);

        base = cnt_a; b0 = beats_a;
        push_frame(R * C);
        pulse_start_a();
        chk("restart_error_cleared", 32'(err_a), 0);
        wait_done_a("restart_done");
        tick(3);
        check_counts("restart", cnt_a, base, 1, R - 1, R, R * (C - 1), R * C, R * C);
        chk("restart_beats", beats_a - b0, R * C);
        chk("restart_error", 32'(err_a), 0);

        // Reset while pixel (1,1) is settling.
        base = cnt_a; b0 = beats_a; f0 = fd_cnt_a;
        push_frame(R * C);
        pulse_start_a();
        seen = 0; n = 0;
        while (n < 2000) begin
            if (adc_start_a) seen++;
            if (seen == 4) break;
            tick(1);
            n++;
        end
        chk("rst_fourth_conv", seen, 4);
        n = 0;
        while (!inphi_a && n < 500) begin tick(1); n++; end
        chk("rst_inphi_11", 32'(inphi_a), 1);
        tick(2 * PC + 1);
        chk("rst_in_settle_adc", cnt_a[5] - base[5], 4);
        reset = 1'b1;
        tick(1);
        chk("rst_outputs_zero", 32'({busy_a, fd_a, err_a, resv_a, incv_a, resp_a, incp_a, inphi_a, adc_start_a,
                                     pix_valid_a, pix_data_a, pix_row_a, pix_col_a}), 0);
        reset = 1'b0;
        chk("rst_pending_beats", exp_q.size(), 2);
        exp_q.delete();
        tick(3);
        chk("rst_beats", beats_a - b0, 4);
        chk("rst_no_frame_done", fd_cnt_a - f0, 0);

        base = cnt_a; b0 = beats_a; f0 = fd_cnt_a;
        push_frame(R * C);
        pulse_start_a();
        wait_done_a("post_rst_done");
        tick(3);
        check_counts("post_rst", cnt_a, base, 1, R - 1, R, R * (C - 1), R * C, R * C);
        chk("post_rst_beats", beats_a - b0, R * C);
        chk("post_rst_frame_done", fd_cnt_a - f0, 1);
        chk("post_rst_queue_empty", exp_q.size(), 0);

        // Single-pixel geometry.
        base = cnt_b; b0 = beats_b; f0 = fd_cnt_b;
        bb.row = 1'b0; bb.col = 2'd0; bb.data = 10'h100;
        exp_qb.push_back(bb);
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        n = 0;
        while (!fd_b && n < 500) begin tick(1); n++; end
        chk("one_px_done", 32'(fd_b), 1);
        tick(3);
        check_counts("one_px", cnt_b, base, 1, 0, 1, 0, 1, 1);
        chk("one_px_beats", beats_b - b0, 1);
        chk("one_px_frame_done", fd_cnt_b - f0, 1);
        chk("one_px_queue_empty", exp_qb.size(), 0);
        chk("one_px_busy", 32'(busy_b), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
